// File: rtl/apb_csr_bank.sv
// APB3 control/status register bank with a blocking push/pop stream window.
// Optional stall timeout is enabled by defining APB_CSR_TIMEOUT_EN.
module apb_csr_bank #(
  parameter int          NUM_CTRL = 8,
  parameter int          NUM_STAT = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] BLOCK_ID = 32'h5242_0200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic [39:0]              paddr,
  input  logic                     pwrite,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_CTRL*32-1:0]   ctrl_q,
  output logic [NUM_CTRL-1:0]      ctrl_wr_pulse,
  input  logic [NUM_STAT*32-1:0]   stat_d,
  output logic [31:0]              strm_wr_data,
  output logic                     strm_wr_en,
  input  logic                     strm_wr_full,
  input  logic [31:0]              strm_rd_data,
  output logic                     strm_rd_en,
  input  logic                     strm_rd_empty
);

  // state | meaning
  // IDLE  | no access pending, or a non-blocking access completing now
  // STALL | stream access held off with pready=0 until the FIFO side is ready
  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state;
  logic        access;
  logic [3:0]  page;
  logic [5:0]  widx;
  logic        sel_id, sel_wr, sel_status, sel_rd, sel_clr, sel_ctrl, sel_stat;
  logic        is_ro, is_wo, dec_err, blocked, to_hit, done, err_now, sticky_rd;
  logic [31:0] rd_word;

  assign access = psel & penable;
  assign page   = paddr[11:8];
  assign widx   = paddr[7:2];

  assign sel_id     = (page == 4'h0) && (widx == 6'd0);
  assign sel_wr     = (page == 4'h0) && (widx == 6'd1);
  assign sel_status = (page == 4'h0) && (widx == 6'd2);
  assign sel_rd     = (page == 4'h0) && (widx == 6'd3);
  assign sel_clr    = (page == 4'h0) && (widx == 6'd4);
  assign sel_ctrl   = (page == 4'h1) && (int'({26'd0, widx}) < NUM_CTRL);
  assign sel_stat   = (page == 4'h2) && (int'({26'd0, widx}) < NUM_STAT);

  assign is_ro   = sel_id | sel_status | sel_rd | sel_stat;
  assign is_wo   = sel_wr | sel_clr;
  assign dec_err = ~(is_ro | is_wo | sel_ctrl) | (pwrite & is_ro) | (~pwrite & is_wo);
  assign blocked = ~dec_err & ((sel_wr & pwrite & strm_wr_full) |
                               (sel_rd & ~pwrite & strm_rd_empty));

`ifdef APB_CSR_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        sticky;
  // The first stalled cycle happens in IDLE, so the count lags by one.
  assign to_hit    = blocked && (state == STALL) && ((wait_cnt + 16'd1) == TIMEOUT_W);
  assign sticky_rd = sticky;
`else
  assign to_hit    = 1'b0;
  assign sticky_rd = 1'b0;
`endif

  // A clearing condition means blocked=0, so normal completion beats timeout.
  assign done    = ~reset & access & (~blocked | to_hit);
  assign err_now = done & (dec_err | to_hit);

  always_comb begin
    rd_word = '0;
    if (sel_id)     rd_word = BLOCK_ID;
    if (sel_status) rd_word = {29'd0, sticky_rd, strm_rd_empty, strm_wr_full};
    if (sel_rd)     rd_word = strm_rd_data;
    if (sel_ctrl) begin
      for (int i = 0; i < NUM_CTRL; i++)
        if (widx == 6'(i)) rd_word = ctrl_q[i*32 +: 32];
    end
    if (sel_stat) begin
      for (int i = 0; i < NUM_STAT; i++)
        if (widx == 6'(i)) rd_word = stat_d[i*32 +: 32];
    end
  end

  assign pready  = done;
  assign pslverr = err_now;
  assign prdata  = (done && !err_now && !pwrite) ? rd_word : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ctrl_q        <= '0;
      ctrl_wr_pulse <= '0;
      strm_wr_data  <= '0;
      strm_wr_en    <= 1'b0;
      strm_rd_en    <= 1'b0;
`ifdef APB_CSR_TIMEOUT_EN
      wait_cnt      <= '0;
      sticky        <= 1'b0;
`endif
    end else begin
      ctrl_wr_pulse <= '0;
      strm_wr_en    <= 1'b0;
      strm_rd_en    <= 1'b0;
      if (done && !err_now && pwrite) begin
        if (sel_ctrl) begin
          for (int i = 0; i < NUM_CTRL; i++) begin
            if (widx == 6'(i)) begin
              ctrl_q[i*32 +: 32] <= pwdata;
              ctrl_wr_pulse[i]   <= 1'b1;
            end
          end
        end
        if (sel_wr) begin
          strm_wr_en   <= 1'b1;
          strm_wr_data <= pwdata;
        end
`ifdef APB_CSR_TIMEOUT_EN
        if (sel_clr) sticky <= 1'b0;
`endif
      end
      if (done && !err_now && !pwrite && sel_rd) strm_rd_en <= 1'b1;
`ifdef APB_CSR_TIMEOUT_EN
      if (done && to_hit) sticky <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (access && blocked) begin
            state <= STALL;
`ifdef APB_CSR_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        STALL: begin
          // Dropping psel mid-stall abandons the access without a strobe.
          if (!access || done) begin
            state <= IDLE;
          end else begin
`ifdef APB_CSR_TIMEOUT_EN
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_cfg;
  assign unused_cfg = ^{paddr[39:12], paddr[1:0], TIMEOUT_W};

endmodule

// File: tb/tb_apb_csr_bank.sv
// Scoreboard bench for apb_csr_bank: a driver predicts each access from an
// address-map model, a monitor checks bus completions and the following strobes.
module tb_apb_csr_bank;
  localparam int          NC  = 8;
  localparam int          NS  = 4;
  localparam int          TO  = 4;
  localparam logic [31:0] BID = 32'h5242_0200;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [39:0]       paddr = '0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic [NC*32-1:0]  ctrl_q;
  logic [NC-1:0]     ctrl_wr_pulse;
  logic [NS*32-1:0]  stat_d = '0;
  logic [31:0]       strm_wr_data;
  logic              strm_wr_en;
  logic              strm_wr_full = 1'b0;
  logic [31:0]       strm_rd_data;
  logic              strm_rd_en;
  logic              strm_rd_empty;

  apb_csr_bank #(.NUM_CTRL(NC), .NUM_STAT(NS), .TIMEOUT(TO), .BLOCK_ID(BID)) dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .ctrl_q(ctrl_q), .ctrl_wr_pulse(ctrl_wr_pulse),
    .stat_d(stat_d), .strm_wr_data(strm_wr_data), .strm_wr_en(strm_wr_en),
    .strm_wr_full(strm_wr_full), .strm_rd_data(strm_rd_data),
    .strm_rd_en(strm_rd_en), .strm_rd_empty(strm_rd_empty)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Upstream FIFO feeding the pop side; head advances on each pop strobe.
  logic [31:0] fifo_mem [64];
  int          f_head = 0;
  int          f_tail = 0;
  logic        rd_blk = 1'b0;
  assign strm_rd_empty = rd_blk | (f_head == f_tail);
  assign strm_rd_data  = fifo_mem[f_head[5:0]];
  always @(posedge clk) if (strm_rd_en) f_head <= f_head + 1;

  typedef struct {
    logic [31:0]      rdata;
    logic             err;
    int               stall;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic             rd_en;
    logic [NC-1:0]    pulse;
    logic [NC*32-1:0] ctrl;
  } exp_t;

  exp_t             sb[$];
  logic [NC*32-1:0] m_ctrl = '0;
  logic             m_sticky = 1'b0;
  logic [31:0]      mq[$];

  task automatic push_fifo(input logic [31:0] d);
    fifo_mem[f_tail[5:0]] = d;
    f_tail++;
    mq.push_back(d);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic xfer(input logic [39:0] a, input logic w, input logic [31:0] d, input int blk);
    exp_t e;
    int   off, eff, idx;
    bit   timed, fin;
    off = int'(a[11:2]) * 4;
    e.rdata = 0; e.err = 0; e.stall = 0; e.wr_en = 0; e.wr_data = 0; e.rd_en = 0; e.pulse = 0;
    eff = (off == 12 && mq.size() == 0) ? 1000000 : blk;
    timed = 0;
`ifdef APB_CSR_TIMEOUT_EN
    if ((off == 4 && w) || (off == 12 && !w)) timed = (eff > TO);
`endif
    if (off == 0) begin
      if (w) e.err = 1; else e.rdata = BID;
    end else if (off == 4) begin
      if (!w) e.err = 1;
      else if (timed) begin e.err = 1; e.stall = TO; m_sticky = 1; end
      else begin e.stall = eff; e.wr_en = 1; e.wr_data = d; end
    end else if (off == 8) begin
      if (w) e.err = 1;
      else e.rdata = {29'd0, m_sticky, mq.size() == 0, 1'b0};
    end else if (off == 12) begin
      if (w) e.err = 1;
      else if (timed) begin e.err = 1; e.stall = TO; m_sticky = 1; end
      else begin e.stall = eff; e.rdata = mq.pop_front(); e.rd_en = 1; end
    end else if (off == 16) begin
      if (!w) e.err = 1;
`ifdef APB_CSR_TIMEOUT_EN
      else m_sticky = 0;
`endif
    end else if (off >= 256 && off < 256 + 4 * NC) begin
      idx = (off - 256) / 4;
      if (w) begin m_ctrl[idx*32 +: 32] = d; e.pulse[idx] = 1'b1; end
      else e.rdata = m_ctrl[idx*32 +: 32];
    end else if (off >= 512 && off < 512 + 4 * NS) begin
      idx = (off - 512) / 4;
      if (w) e.err = 1; else e.rdata = stat_d[idx*32 +: 32];
    end else begin
      e.err = 1;
    end
    e.ctrl = m_ctrl;
    sb.push_back(e);

    psel = 1; penable = 0; paddr = a; pwrite = w; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    fin = 0;
    for (int n = 0; n < 100; n++) begin
      strm_wr_full = (off == 4) && (n < blk);
      rd_blk       = (off == 12) && (n < blk);
      @(negedge clk);
      if (pready) begin fin = 1; break; end
      @(posedge clk); #1;
    end
    if (!fin) chk32("bus_completion_timeout", 32'(fin), 32'd1);
    @(posedge clk); #1;
    psel = 0; penable = 0; strm_wr_full = 0; rd_blk = 0;
  endtask

  // Monitor: bus completions against the scoreboard, then strobes one cycle later.
  exp_t pend;
  bit   pend_v = 0;
  int   stall = 0;
  always @(negedge clk) begin
    if (reset) begin
      pend_v = 0;
      stall = 0;
    end else begin
      if (pend_v) begin
        chk32("strm_wr_en", 32'(strm_wr_en), 32'(pend.wr_en));
        if (pend.wr_en) chk32("strm_wr_data", strm_wr_data, pend.wr_data);
        chk32("strm_rd_en", 32'(strm_rd_en), 32'(pend.rd_en));
        chk32("ctrl_wr_pulse", 32'(ctrl_wr_pulse), 32'(pend.pulse));
        for (int i = 0; i < NC; i++)
          chk32($sformatf("ctrl_q[%0d]", i), ctrl_q[i*32 +: 32], pend.ctrl[i*32 +: 32]);
        pend_v = 0;
      end else begin
        chk32("idle_strobes", {22'd0, strm_wr_en, strm_rd_en, ctrl_wr_pulse}, 32'd0);
      end
      if (psel && penable) begin
        if (pready) begin
          if (sb.size() == 0) chk32("unexpected_completion", 32'd1, 32'd0);
          else begin
            pend = sb.pop_front();
            chk32("prdata", prdata, pend.rdata);
            chk32("pslverr", 32'(pslverr), 32'(pend.err));
            chk32("wait_states", 32'(stall), 32'(pend.stall));
            pend_v = 1;
          end
          stall = 0;
        end else stall++;
      end else stall = 0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk32({tag, "_ctrl_pulse"}, 32'(ctrl_wr_pulse), 32'd0);
    chk32({tag, "_wr_en"}, 32'(strm_wr_en), 32'd0);
    chk32({tag, "_wr_data"}, strm_wr_data, 32'd0);
    chk32({tag, "_rd_en"}, 32'(strm_rd_en), 32'd0);
    for (int i = 0; i < NC; i++) chk32($sformatf("%s_ctrl_q[%0d]", tag, i), ctrl_q[i*32 +: 32], 32'd0);
  endtask

  initial begin
    logic [39:0] a;
    logic        w;
    int          sel, blk;
    for (int i = 0; i < NS; i++) stat_d[i*32 +: 32] = $urandom();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk32("rst_pready", 32'(pready), 32'd0);
    chk32("rst_pslverr", 32'(pslverr), 32'd0);
    chk32("rst_prdata", prdata, 32'd0);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 0;

    xfer(40'h104, 1, 32'hDEAD_BEEF, 0);
    xfer(40'h104, 0, 0, 0);
    xfer(40'h300, 1, 32'h1111_2222, 0);
    xfer(40'h200, 1, 32'h3333_4444, 0);
    xfer(40'h000, 0, 0, 0);
    xfer(40'h004, 1, 32'h1234_5678, 5);
    push_fifo(32'hA);
    push_fifo(32'hB);
    xfer(40'h00C, 0, 0, 0);
    xfer(40'h00C, 0, 0, 0);
`ifdef APB_CSR_TIMEOUT_EN
    xfer(40'h00C, 0, 0, 1000);
    xfer(40'h008, 0, 0, 0);
    xfer(40'h010, 1, 0, 0);
    xfer(40'h008, 0, 0, 0);
    xfer(40'h004, 1, 32'hCAFE_0004, TO);
`endif
    xfer(40'h008, 0, 0, 0);
    xfer(40'h010, 1, 32'h5, 0);
    xfer(40'h00C, 1, 0, 0);
    xfer(40'h004, 0, 0, 0);

    for (int t = 0; t < 200; t++) begin
      sel = $urandom_range(0, 11);
      w   = 1'($urandom_range(0, 1));
      blk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 6) : 0;
      case (sel)
        0:       a = 40'h000;
        1:       a = 40'h004;
        2:       a = 40'h008;
        3, 4:    begin a = 40'h00C; w = 0; end
        5:       a = 40'h010;
        6, 7, 8: a = 40'h100 + 40'(4 * $urandom_range(0, NC - 1));
        9:       a = 40'h200 + 40'(4 * $urandom_range(0, NS - 1));
        default: begin
          case ($urandom_range(0, 5))
            0: a = 40'h014;
            1: a = 40'h100 + 40'(4 * NC);
            2: a = 40'h200 + 40'(4 * NS);
            3: a = 40'h300;
            4: a = 40'hFFC;
            default: a = 40'h0FC;
          endcase
        end
      endcase
      a[39:12] = 28'($urandom());
      a[1:0]   = 2'($urandom_range(0, 3));
      if (a[11:0] >= 12'h00C && a[11:0] < 12'h010 && !w && mq.size() == 0) push_fifo($urandom());
      if (t % 25 == 0) for (int i = 0; i < NS; i++) stat_d[i*32 +: 32] = $urandom();
      xfer(a, w, $urandom(), blk);
    end

    // Reset lands in the middle of a stalled push: no completion, no strobe.
    psel = 1; penable = 0; paddr = 40'h004; pwrite = 1; pwdata = 32'h0BAD_F00D;
    strm_wr_full = 1;
    @(posedge clk); #1;
    penable = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    @(negedge clk);
    chk32("midrst_pready", 32'(pready), 32'd0);
    chk32("midrst_pslverr", 32'(pslverr), 32'd0);
    chk32("midrst_prdata", prdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 0; psel = 0; penable = 0; strm_wr_full = 0;
    m_ctrl = '0;
    m_sticky = 0;
    @(posedge clk); #1;
    xfer(40'h104, 0, 0, 0);
    xfer(40'h008, 0, 0, 0);

    repeat (3) @(posedge clk);
    chk32("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_csr_bank.md
# apb_csr_bank

Parametrised APB3 control/status register bank with a blocking 32-bit stream port. It replaces the fixed single-purpose register decoder between the processing system's APB master and the fabric. It provides NUM_CTRL read/write control words with per-register write strobes, NUM_STAT read-only status words, and a stream push/pop window. The window stalls the bus with `pready` instead of requiring software to poll FIFO full/empty flags.

## Interface

Parameters:
- NUM_CTRL, 8, number of 32-bit RW control registers (1..64)
- NUM_STAT, 4, number of 32-bit RO status registers (1..64)
- TIMEOUT, 255, maximum stall cycles before error completion (1..65535)
- BLOCK_ID, 32'h5242_0200, value returned at offset 0x000

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock
- reset  in  1  synchronous active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- paddr  in  40  APB address; only [11:2] decoded
- pwrite  in  1  1 = write
- pwdata  in  32  write data
- prdata  out  32  read data, combinational, valid when pready=1
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid when pready=1
- ctrl_q  out  NUM_CTRL*32  control register contents; word i at [32i+31:32i]
- ctrl_wr_pulse  out  NUM_CTRL  one-cycle strobe after a write to control i
- stat_d  in  NUM_STAT*32  status inputs, sampled combinationally on read
- strm_wr_data  out  32  push data
- strm_wr_en  out  1  push strobe, one cycle
- strm_wr_full  in  1  downstream FIFO full
- strm_rd_data  in  32  first-word-fall-through pop data
- strm_rd_en  out  1  pop strobe, one cycle
- strm_rd_empty  in  1  upstream FIFO empty

## Operation

- Address map (byte offsets, paddr[11:2]):
  - 0x000 ID (RO)
  - 0x004 STRM_WR (WO)
  - 0x008 STRM_STATUS (RO; bit0 wr_full, bit1 rd_empty, bit2 sticky timeout flag)
  - 0x00C STRM_RD (RO)
  - 0x010 ERR_CLR (WO; any write clears the sticky flag)
  - 0x100+4i CTRL[i]
  - 0x200+4i STAT[i]
- Unmapped offset, write to an RO register, or read of a WO register: completes with zero wait states, pslverr=1, prdata=0, no side effects.
- CTRL, STAT, ID, STATUS and ERR_CLR accesses complete with zero wait states (pready=1 in the first access cycle).
- A CTRL write updates ctrl_q[i] at the completing edge. ctrl_wr_pulse[i] is high for exactly the following cycle.
- STRM_WR is a blocking access:
  - Completes in the first access cycle with strm_wr_full=0.
  - strm_wr_data and strm_wr_en are registered and appear the cycle after completion.
- STRM_RD is a blocking access:
  - Completes in the first access cycle with strm_rd_empty=0.
  - prdata=strm_rd_data in that cycle.
  - strm_rd_en pulses the cycle after completion.
- FSM:
  - IDLE → STALL when an access phase targets a blocked stream register.
  - STALL → IDLE on the completing cycle (condition clears or timeout).
  - wait_cnt (16 bit) clears on entry to STALL and increments each stalled cycle.
- Access while psel drops mid-stall (protocol violation): return to IDLE, no strobe.
- Simultaneous timeout and condition clearing in the same cycle: normal completion wins.

## Timing

- Reset values: ctrl_q=0, ctrl_wr_pulse=0, strm_wr_en=0, strm_wr_data=0, strm_rd_en=0, sticky flag=0, FSM=IDLE, wait_cnt=0.
- During reset: pready=0, pslverr=0, prdata=0.
- Reset asserted mid-stall: abort with no strobe issued; the bus sees no completion.
- Back-to-back pops: the earliest following access phase is 2 cycles after completion. The pop strobe lands in the next setup phase, so FIFO data is updated before the next access.
- Strobe latency: exactly 1 cycle after the completing edge, for all pulses.

## Configuration

- APB_CSR_TIMEOUT_EN defined:
  - A stall reaching wait_cnt == TIMEOUT completes with pready=1, pslverr=1 and prdata=0.
  - No push or pop occurs.
  - The sticky timeout flag is set.
- APB_CSR_TIMEOUT_EN undefined:
  - Stalls last indefinitely and wait_cnt is not implemented.
  - STATUS bit2 reads 0 and ERR_CLR is a no-op write (no error).

## Test plan

- Write 0xDEADBEEF to 0x104 → pready=1 in the first access cycle; ctrl_q[63:32]=0xDEADBEEF; ctrl_wr_pulse=8'b0000_0010 for one cycle; read-back matches.
- Write to 0x300 (unmapped) and to 0x200 (STAT, RO) → pslverr=1 with zero wait states; ctrl_q unchanged; no strobes.
- STRM_WR 0x12345678 with strm_wr_full held high 5 cycles → pready low 5 cycles; completes in cycle 6; strm_wr_en=1 with data 0x12345678 one cycle later, exactly once.
- Two back-to-back STRM_RD accesses against a FIFO model holding 0xA, 0xB → prdata 0xA then 0xB; strm_rd_en pulses exactly twice.
- With APB_CSR_TIMEOUT_EN and TIMEOUT=4, STRM_RD with strm_rd_empty=1 → completion after 4 stall cycles with pslverr=1; no pop; STATUS reads 0x6 (rd_empty and sticky flag set); after an ERR_CLR write, STATUS reads 0x2.
- Assert reset during a STRM_WR stall → no strm_wr_en; all outputs at reset values; after release, a CTRL read returns 0.
